vga_pixfmt: RTL and testbench
=============================

// Module: vga_pixfmt
// PURPOSE
//  Parametrised pixel fetch/format stage between the framebuffer read port and the VGA pins.
//  - Buffers bus words from the framebuffer in a small FIFO.
//  - Unpacks one pixel per pixel-clock enable during active display.
//  - Expands RGB332/444/555/565/888 to 8-bit channels and flags underflow.
//  - Generalises the fixed 64-bit, 4-pixel fetch of vga_core; the timing generator drives pclk_en_i/de_i/vend_i.
// PARAMETERS
//  BUS_WIDTH  64  framebuffer word width; must be 32, 64 or 128
//  DEPTH      4   FIFO depth in bus words; power of two, >= 2
//  CNT_W      $clog2(DEPTH)+1  (localparam) FIFO occupancy width
// PORTS
//  clk_i          in   1          system clock
//  rst_n_i        in   1          asynchronous reset, active low
//  en_i           in   1          block enable; 0 = FIFO flushed, outputs black, ready low
//  mode_i         in   3          pixel format: 0 RGB332, 1 RGB444, 2 RGB555, 3 RGB565, 4 RGB888; 5-7 reserved
//  pclk_en_i      in   1          one-clk strobe per pixel period
//  de_i           in   1          active-display qualifier, valid with pclk_en_i
//  vend_i         in   1          end-of-frame strobe
//  pixel_valid_i  in   1          upstream word valid
//  pixel_ready_o  out  1          upstream word ready
//  pixel_data_i   in   BUS_WIDTH  upstream word; pixel 0 in the LSBs
//  vga_r_o        out  8          red, expanded
//  vga_g_o        out  8          green, expanded
//  vga_b_o        out  8          blue, expanded
//  underflow_o    out  1          sticky underflow flag
//  clr_uf_i       in   1          clear underflow flag
//  fifo_cnt_o     out  CNT_W      FIFO occupancy in words
// BEHAVIOUR
//  Reset: FIFO empty, sub-index 0, active mode RGB565, and all outputs 0 (including pixel_ready_o).
//  Handshake:
//  - pixel_ready_o = en_i & ~full & ~vend_i (combinational).
//  - A push occurs on valid & ready.
//  - Push and pop in the same clk leave the count unchanged.
//  Mode/bpp:
//  - Active mode is sampled from mode_i on vend_i, or while en_i=0; never changes mid-frame.
//  - bpp = 8 / 16 / 16 / 16 / 32. RGB888 occupies a 32-bit slot, bits [23:0], upper 8 ignored.
//  - PPW (pixels per word) = BUS_WIDTH / bpp. The sub-index counts 0..PPW-1.
//  Pixel step, on pclk_en_i & de_i & en_i:
//  - FIFO not empty: register the pixel at sub-index from the FIFO head. Sub-index +1.
//  - At PPW-1: wrap sub-index to 0 and pop the head in the same clk.
//  - FIFO empty: register black, set underflow_o, do not advance the sub-index.
//  - pclk_en_i & ~de_i: register black, no advance.
//  - No pclk_en_i: RGB outputs hold.
//  Latency: RGB is valid 1 clk after the qualifying pclk_en_i strobe.
//  Expansion: channel MSB-replicated to 8 bits.
//  - 5b: {c, c[4:2]}; 6b: {c, c[5:4]}; 4b: {c, c}; 3b: {c, c, c[2:1]}; 2b: {c, c, c, c}.
//  - RGB332 byte = R[7:5] G[4:2] B[1:0]. 444 = R[11:8]. 555 = R[14:10]. 565 = R[15:11]/G[10:5].
//  - Reserved modes output black and never pop.
//  Frame resync: vend_i flushes the FIFO and zeroes the sub-index.
//  - Ready is low in that clk, so no word is lost mid-push.
//  - The next frame starts at pixel 0 of the next word.
//  underflow_o: set on an empty-FIFO pixel step; cleared only by clr_uf_i.
//  - Set has priority over clear in the same clk.
//  - Not cleared by vend_i or en_i.
//  en_i=0: acts as a continuous flush; outputs black after 1 clk.
// STRUCTURE
//  vga_pkg (shared):
//  - vga_mode_e enum (RGB332..RGB888).
//  - function vga_bpp(mode).
//  - function vga_expand(value, width) -> 8 bits.
//  - Package constants replace the per-mode macros.
//  Sub-module vga_fifo #(WIDTH, DEPTH):
//  - Sync FIFO: push/pop/flush, full/empty/cnt, head visible combinationally.
//  - Head read is not registered, so the pop and the pixel use the same word in the same clk.
//  Top: sub-index counter, mode latch, unpack mux, expansion, output registers, underflow flag.
// TESTING
//  1. BUS=64, RGB565, push 64'hF800_07E0_001F_FFFF, 4 strobes with de_i=1
//     -> RGB FF/FF/FF, 00/00/FF, 00/FF/00, FF/00/00.
//     -> fifo_cnt_o 1 -> 0 on the 4th strobe.
//  2. RGB332, word with byte0=8'hE0, byte1=8'h03 -> pixel0 FF/00/00, pixel1 00/00/FF.
//     -> The pop happens only after 8 strobes.
//  3. No pushes, de_i=1, 3 strobes -> RGB 00 each, underflow_o=1 after the first.
//     -> underflow_o holds through vend_i; clears 1 clk after clr_uf_i.
//  4. pixel_valid_i held high, de_i=0 -> exactly DEPTH words accepted, pixel_ready_o=0.
//     -> fifo_cnt_o=DEPTH. One pop re-raises ready the next clk.
//  5. vend_i after 2 of 4 pixels (RGB565)
//     -> fifo_cnt_o=0, ready low that clk.
//     -> The first pixel of the next frame is bits[15:0] of a new word; mode_i change applied.
//  6. rst_n_i low mid-line -> all outputs 0 immediately; the first post-reset pixel needs a new push.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared pixel-format definitions for the VGA pixel fetch/format stage:
// mode encoding, bits-per-pixel lookup and MSB-replicating channel expansion.
package vga_pkg;

  typedef enum logic [2:0] {
    RGB332 = 3'd0,
    RGB444 = 3'd1,
    RGB555 = 3'd2,
    RGB565 = 3'd3,
    RGB888 = 3'd4
  } vga_mode_e;

  // Mode restored by reset
  localparam logic [2:0] MODE_RESET = RGB565;

  // Per-mode slot sizes in bits
  localparam int BPP_8  = 8;
  localparam int BPP_16 = 16;
  localparam int BPP_32 = 32;

  // Widest slot actually carrying colour (RGB888 uses the low 24 of 32 bits)
  localparam int SLOT_W = 24;

  // Bits per pixel slot for a mode; 0 for reserved encodings
  function automatic int vga_bpp(input logic [2:0] mode);
    case (mode)
      RGB332:                 return BPP_8;
      RGB444, RGB555, RGB565: return BPP_16;
      RGB888:                 return BPP_32;
      default:                return 0;
    endcase
  endfunction

  // Expand a width-bit channel (right-aligned in value) to 8 bits by
  // repeating the channel from its MSB downwards until 8 bits are filled.
  function automatic logic [7:0] vga_expand(input logic [7:0] value, input int width);
    logic [7:0] res;
    logic [2:0] sel;
    res = '0;
    if (width >= 1 && width <= 8) begin
      for (int i = 0; i < 8; i++) begin
        sel    = 3'(width - 1 - ((7 - i) % width));
        res[i] = value[sel];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_fifo.sv
// Small synchronous FIFO of framebuffer words. The head word is visible
// combinationally so the consumer can read a pixel and pop in the same clock.
module vga_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointer and occupancy next-state; flush empties the FIFO outright
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Word storage; data needs no reset because occupancy gates its use
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/vga_pixfmt.sv
// Pixel fetch/format stage: buffers framebuffer words, unpacks one pixel per
// pixel-clock enable during active display, expands the selected format to
// 8-bit RGB and keeps a sticky underflow flag for empty-FIFO pixel steps.
module vga_pixfmt
  import vga_pkg::*;
#(
  parameter  int BUS_WIDTH = 64,
  parameter  int DEPTH     = 4,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [2:0]           mode_i,
  input  logic                 pclk_en_i,
  input  logic                 de_i,
  input  logic                 vend_i,
  input  logic                 pixel_valid_i,
  output logic                 pixel_ready_o,
  input  logic [BUS_WIDTH-1:0] pixel_data_i,
  output logic [7:0]           vga_r_o,
  output logic [7:0]           vga_g_o,
  output logic [7:0]           vga_b_o,
  output logic                 underflow_o,
  input  logic                 clr_uf_i,
  output logic [CNT_W-1:0]     fifo_cnt_o
);

  // Sub-index must cover the densest packing (8 bpp)
  localparam int IDX_W = $clog2(BUS_WIDTH / BPP_8);
  localparam int SH_W  = $clog2(BUS_WIDTH);

  logic [BUS_WIDTH-1:0] head;
  logic                 full, empty;
  logic                 push, pop, flush;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       mode_q, mode_d;
  logic [7:0]       r_q, g_q, b_q;
  logic [7:0]       r_d, g_d, b_d;
  logic             uf_q, uf_d;

  logic [IDX_W-1:0]  ppw_m1;
  logic [SH_W-1:0]   sh;
  logic [SLOT_W-1:0] slot;
  logic              mode_ok;
  logic [7:0]        pr, pg, pb;
  logic              step, fetch, last;

  // Ready also drops while reset is asserted so all outputs read 0 in reset
  assign pixel_ready_o = rst_n_i & en_i & ~full & ~vend_i;
  assign push          = pixel_valid_i & pixel_ready_o;
  assign flush         = vend_i | ~en_i;

  vga_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (pixel_data_i),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (fifo_cnt_o)
  );

  // Slot selection and channel expansion for the active mode
  always_comb begin
    mode_ok = 1'b1;
    ppw_m1  = '0;
    sh      = '0;
    case (mode_q)
      RGB332: begin
        ppw_m1 = IDX_W'(BUS_WIDTH / vga_bpp(RGB332) - 1);
        sh     = SH_W'(idx_q) << 3;
      end
      RGB444, RGB555, RGB565: begin
        ppw_m1 = IDX_W'(BUS_WIDTH / vga_bpp(RGB565) - 1);
        sh     = SH_W'(idx_q) << 4;
      end
      RGB888: begin
        ppw_m1 = IDX_W'(BUS_WIDTH / vga_bpp(RGB888) - 1);
        sh     = SH_W'(idx_q) << 5;
      end
      default: mode_ok = 1'b0;
    endcase

    slot = SLOT_W'(head >> sh);

    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_q)
      RGB332: begin
        pr = vga_expand({5'b0, slot[7:5]}, 3);
        pg = vga_expand({5'b0, slot[4:2]}, 3);
        pb = vga_expand({6'b0, slot[1:0]}, 2);
      end
      RGB444: begin
        pr = vga_expand({4'b0, slot[11:8]}, 4);
        pg = vga_expand({4'b0, slot[7:4]}, 4);
        pb = vga_expand({4'b0, slot[3:0]}, 4);
      end
      RGB555: begin
        pr = vga_expand({3'b0, slot[14:10]}, 5);
        pg = vga_expand({3'b0, slot[9:5]}, 5);
        pb = vga_expand({3'b0, slot[4:0]}, 5);
      end
      RGB565: begin
        pr = vga_expand({3'b0, slot[15:11]}, 5);
        pg = vga_expand({2'b0, slot[10:5]}, 6);
        pb = vga_expand({3'b0, slot[4:0]}, 5);
      end
      RGB888: begin
        pr = slot[23:16];
        pg = slot[15:8];
        pb = slot[7:0];
      end
      default: begin
        pr = '0;
        pg = '0;
        pb = '0;
      end
    endcase
  end

  assign step  = pclk_en_i & de_i & en_i;
  assign fetch = step & ~empty & mode_ok;
  assign last  = (idx_q == ppw_m1);
  assign pop   = fetch & last;

  // Next-state for sub-index, mode latch, RGB registers and underflow flag
  always_comb begin
    idx_d  = idx_q;
    mode_d = mode_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    uf_d   = uf_q;

    if (flush) begin
      idx_d  = '0;
      mode_d = mode_i;
    end else if (fetch) begin
      idx_d = last ? '0 : idx_q + 1'b1;
    end

    if (!en_i) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end else if (pclk_en_i) begin
      r_d = fetch ? pr : 8'h00;
      g_d = fetch ? pg : 8'h00;
      b_d = fetch ? pb : 8'h00;
    end

    if (step && empty) uf_d = 1'b1;
    else if (clr_uf_i) uf_d = 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q  <= '0;
      mode_q <= MODE_RESET;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      uf_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      mode_q <= mode_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      uf_q   <= uf_d;
    end
  end

  assign vga_r_o     = r_q;
  assign vga_g_o     = g_q;
  assign vga_b_o     = b_q;
  assign underflow_o = uf_q;

endmodule

// File: tb/tb_vga_pixfmt.sv
// Directed bench for vga_pixfmt (BUS_WIDTH=64, DEPTH=4) with an expected-pixel
// scoreboard: each pixel strobe queues its expected RGB, which is popped and
// compared once the registered output is available.
module tb_vga_pixfmt;

  localparam int BW    = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic             pclk_en;
  logic             de;
  logic             vend;
  logic             pvalid;
  logic             pready;
  logic [BW-1:0]    pdata;
  logic [7:0]       r, g, b;
  logic             uf;
  logic             clr;
  logic [CNT_W-1:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [23:0] exp_q [$];
  logic [BW-1:0] words [DEPTH];
  int acc;

  always #5 clk = ~clk;

  vga_pixfmt #(
    .BUS_WIDTH (BW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .en_i          (en),
    .mode_i        (mode),
    .pclk_en_i     (pclk_en),
    .de_i          (de),
    .vend_i        (vend),
    .pixel_valid_i (pvalid),
    .pixel_ready_o (pready),
    .pixel_data_i  (pdata),
    .vga_r_o       (r),
    .vga_g_o       (g),
    .vga_b_o       (b),
    .underflow_o   (uf),
    .clr_uf_i      (clr),
    .fifo_cnt_o    (cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel-clock strobe; expected RGB queued now, compared one clk later
  task automatic strobe(input logic de_v, input logic [23:0] e);
    logic [23:0] x;
    exp_q.push_back(e);
    @(negedge clk);
    pclk_en = 1'b1;
    de      = de_v;
    @(negedge clk);
    pclk_en = 1'b0;
    de      = 1'b0;
    x = exp_q.pop_front();
    check($sformatf("rgb#%0d", n_chk), {r, g, b}, x);
  endtask

  // Offer one word and wait (bounded) until it is accepted
  task automatic push_word(input logic [BW-1:0] w);
    int t;
    t = 0;
    @(negedge clk);
    pdata  = w;
    pvalid = 1'b1;
    #1;
    while (!pready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t == 20) check("push_ready", pready, 1);
    @(negedge clk);
    pvalid = 1'b0;
  endtask

  task automatic pulse_vend(input logic [2:0] m);
    @(negedge clk);
    mode = m;
    vend = 1'b1;
    @(negedge clk);
    vend = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b1;
    en      = 1'b1;
    mode    = 3'd3;
    pclk_en = 1'b0;
    de      = 1'b0;
    vend    = 1'b0;
    pvalid  = 1'b0;
    pdata   = '0;
    clr     = 1'b0;
    words[0] = 64'h8410_FFE0_001F_F800;
    words[1] = 64'h1234_5678_07E0_FFFF;
    words[2] = 64'h0000_0000_0000_0000;
    words[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rgb", {r, g, b}, 24'h0);
    check("rst_uf", uf, 0);
    check("rst_cnt", cnt, 0);
    check("rst_ready", pready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst", pready, 1);

    // RGB565 word, four pixels, pop on the fourth
    push_word(64'hF800_07E0_001F_FFFF);
    check("t1_cnt_push", cnt, 1);
    strobe(1'b1, 24'hFFFFFF);
    strobe(1'b1, 24'h0000FF);
    strobe(1'b1, 24'h00FF00);
    check("t1_cnt_3", cnt, 1);
    strobe(1'b1, 24'hFF0000);
    check("t1_cnt_4", cnt, 0);

    // RGB332: eight pixels per word
    pulse_vend(3'd0);
    push_word(64'h0000_0000_0049_03E0);
    strobe(1'b1, 24'hFF0000);
    strobe(1'b1, 24'h0000FF);
    strobe(1'b1, 24'h494955);
    for (int i = 0; i < 4; i++) strobe(1'b1, 24'h000000);
    check("t2_cnt_7", cnt, 1);
    strobe(1'b1, 24'h000000);
    check("t2_cnt_8", cnt, 0);
    check("t2_uf_clear", uf, 0);

    // Underflow: sticky through vend, cleared by clr
    strobe(1'b1, 24'h000000);
    check("t3_uf_set", uf, 1);
    strobe(1'b1, 24'h000000);
    strobe(1'b1, 24'h000000);
    pulse_vend(3'd3);
    check("t3_uf_vend", uf, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t3_uf_clr", uf, 0);

    // Fill with valid held high and de low
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      pdata  = words[acc % DEPTH];
      pvalid = 1'b1;
      #1;
      if (pready) acc++;
    end
    @(negedge clk);
    pvalid = 1'b0;
    check("t4_accepted", acc, DEPTH);
    check("t4_cnt_full", cnt, DEPTH);
    check("t4_ready_full", pready, 0);
    strobe(1'b0, 24'h000000);
    check("t4_cnt_de0", cnt, DEPTH);
    strobe(1'b1, 24'hFF0000);
    strobe(1'b1, 24'h0000FF);
    strobe(1'b1, 24'hFFFF00);
    check("t4_ready_still_full", pready, 0);
    strobe(1'b1, 24'h848284);
    check("t4_cnt_pop", cnt, DEPTH - 1);
    check("t4_ready_back", pready, 1);

    // Frame resync after two pixels, switching to RGB444
    strobe(1'b1, 24'hFFFFFF);
    strobe(1'b1, 24'h00FF00);
    @(negedge clk);
    vend = 1'b1;
    mode = 3'd1;
    #1 check("t5_ready_vend", pready, 0);
    @(negedge clk);
    vend = 1'b0;
    check("t5_cnt_flush", cnt, 0);
    push_word(64'h0000_0000_0ABC_0F00);
    strobe(1'b1, 24'hFF0000);
    strobe(1'b1, 24'hAABBCC);

    // Block disable flushes and blanks
    @(negedge clk);
    mode = 3'd3;
    en   = 1'b0;
    @(negedge clk);
    check("en0_rgb", {r, g, b}, 24'h0);
    check("en0_cnt", cnt, 0);
    check("en0_ready", pready, 0);
    en = 1'b1;

    // Asynchronous reset mid-line
    strobe(1'b1, 24'h000000);
    check("t6_uf_pre", uf, 1);
    push_word(64'h0000_0000_0000_FFFF);
    strobe(1'b1, 24'hFFFFFF);
    check("t6_cnt_pre", cnt, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_rgb", {r, g, b}, 24'h0);
    check("t6_rst_cnt", cnt, 0);
    check("t6_rst_uf", uf, 0);
    check("t6_rst_ready", pready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    strobe(1'b1, 24'h000000);
    check("t6_uf_post", uf, 1);
    push_word(64'h0000_0000_0000_F800);
    strobe(1'b1, 24'hFF0000);

    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
